// File: rtl/dfm_pkg.sv
// Shared types and constants for the frequency-measurement gate sequencer.
package dfm_pkg;

  localparam int unsigned TIMER_W = 32;
  localparam logic [TIMER_W-1:0] GATE_MIN = 32'd1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_GATE  = 3'd2,
    ST_CLOSE = 3'd3,
    ST_LATCH = 3'd4
  } state_e;

  // A zero gate length would never expire, so it is raised to the minimum.
  function automatic logic [TIMER_W-1:0] clamp_gate(input logic [TIMER_W-1:0] t);
    return (t < GATE_MIN) ? GATE_MIN : t;
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter that saturates at zero; expiry fires on the decrement from 1.
module gate_timer
  import dfm_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  input  logic               i_dec,
  output logic               o_expire
);

  logic [TIMER_W-1:0] r_count;

  // Counter register: load has priority over decrement.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count <= {TIMER_W{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != {TIMER_W{1'b0}})) begin
      r_count <= r_count - 32'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expire = i_dec && (r_count == 32'd1);

endmodule

// File: rtl/gate_seq.sv
// Gate-window sequencer: arm, count, close on signal edge, latch without tearing a readout.
// Define GATE_SEQ_AUTO_REARM_EN for continuous re-arming after each latch; default is one-shot.
module gate_seq
  import dfm_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [TIMER_W-1:0] gate_time_i,
  input  logic               sig_edge_i,
  input  logic               rd_busy_i,
  output logic               cnt_clr_o,
  output logic               cnt_en_o,
  output logic               latch_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  state_e             r_state;
  logic [TIMER_W-1:0] r_gate_len;
  logic               r_cnt_clr;
  logic               r_cnt_en;
  logic               r_latch;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic               w_start_ok;
  logic               w_timer_load;
  logic [TIMER_W-1:0] w_timer_val;
  logic               w_timer_dec;
  logic               w_expire;

  assign w_start_ok  = start_i && !stop_i;
  assign w_timer_dec = (r_state == ST_ARM) || (r_state == ST_GATE) || (r_state == ST_CLOSE);

  // Timer reload on entry to ARM, GATE and CLOSE.
  always_comb begin
    w_timer_load = 1'b0;
    w_timer_val  = r_gate_len;
    case (r_state)
      ST_IDLE: begin
        w_timer_val  = clamp_gate(gate_time_i);
        w_timer_load = w_start_ok;
      end
      ST_ARM:   w_timer_load = sig_edge_i;
      ST_GATE:  w_timer_load = w_expire;
      ST_CLOSE: w_timer_load = 1'b0;
      ST_LATCH: begin
`ifdef GATE_SEQ_AUTO_REARM_EN
        w_timer_load = !rd_busy_i;
`else
        w_timer_load = 1'b0;
`endif
      end
      default:  w_timer_load = 1'b0;
    endcase
  end

  gate_timer u_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .i_load     (w_timer_load),
    .i_load_val (w_timer_val),
    .i_dec      (w_timer_dec),
    .o_expire   (w_expire)
  );

  // Sequencer state and registered outputs; stop overrides everything outside IDLE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_gate_len <= GATE_MIN;
      r_cnt_clr  <= 1'b0;
      r_cnt_en   <= 1'b0;
      r_latch    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_cnt_clr <= 1'b0;
      r_latch   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      if (stop_i && (r_state != ST_IDLE)) begin
        r_state  <= ST_IDLE;
        r_cnt_en <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start_ok) begin
              r_gate_len <= clamp_gate(gate_time_i);
              r_cnt_clr  <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= ST_ARM;
            end
          end
          ST_ARM: begin
            if (sig_edge_i) begin
              r_cnt_en <= 1'b1;
              r_state  <= ST_GATE;
            end else if (w_expire) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
          ST_GATE: begin
            if (w_expire) begin
              r_state <= ST_CLOSE;
            end
          end
          ST_CLOSE: begin
            if (sig_edge_i) begin
              r_cnt_en <= 1'b0;
              r_state  <= ST_LATCH;
            end else if (w_expire) begin
              r_cnt_en <= 1'b0;
              r_err    <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end
          ST_LATCH: begin
            // Hold off while the host is mid-burst so the readout is never torn.
            if (!rd_busy_i) begin
              r_latch <= 1'b1;
              r_done  <= 1'b1;
`ifdef GATE_SEQ_AUTO_REARM_EN
              r_cnt_clr <= 1'b1;
              r_state   <= ST_ARM;
`else
              r_busy    <= 1'b0;
              r_state   <= ST_IDLE;
`endif
            end
          end
          default: begin
            r_cnt_en <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign cnt_clr_o = r_cnt_clr;
  assign cnt_en_o  = r_cnt_en;
  assign latch_o   = r_latch;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;

endmodule

// File: tb/tb_gate_seq.sv
// Scoreboard bench for gate_seq: expected output events are queued with their cycle
// when stimulus is driven, then popped as the monitor sees each output event.
module tb_gate_seq;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic        stop_i;
  logic [31:0] gate_time_i;
  logic        sig_edge_i;
  logic        rd_busy_i;
  logic        cnt_clr_o;
  logic        cnt_en_o;
  logic        latch_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  localparam int K_CLR  = 0;
  localparam int K_ON   = 1;
  localparam int K_OFF  = 2;
  localparam int K_LAT  = 3;
  localparam int K_DONE = 4;
  localparam int K_ERR  = 5;

  typedef struct {
    int kind;
    int cyc;
  } evt_t;

  evt_t exp_q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic prev_en = 1'b0;

  gate_seq dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .gate_time_i (gate_time_i),
    .sig_edge_i  (sig_edge_i),
    .rd_busy_i   (rd_busy_i),
    .cnt_clr_o   (cnt_clr_o),
    .cnt_en_o    (cnt_en_o),
    .latch_o     (latch_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic push(input int k, input int c);
    exp_q.push_back('{kind: k, cyc: c});
  endtask

  task automatic see(input int k);
    evt_t e;
    if (exp_q.size() == 0) begin
      check_eq($sformatf("unexpected_evt_k%0d", k), k, -1);
    end else begin
      e = exp_q.pop_front();
      check_eq("evt_kind", k, e.kind);
      check_eq($sformatf("evt_cyc_k%0d", k), cyc, e.cyc);
    end
  endtask

  // Output monitor: samples 1 time unit after each rising edge.
  always @(posedge clk_i) begin
    cyc = cyc + 1;
    #1;
    if (rst_n_i) begin
      if (cnt_clr_o)             see(K_CLR);
      if (cnt_en_o && !prev_en)  see(K_ON);
      if (!cnt_en_o && prev_en)  see(K_OFF);
      if (latch_o)               see(K_LAT);
      if (done_o)                see(K_DONE);
      if (err_o)                 see(K_ERR);
    end
    prev_en = cnt_en_o;
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_i);
  endtask

  // One measurement: edge a cycles after start, close edge b cycles after CLOSE entry,
  // rd_busy held for n cycles in LATCH. gate_time_i is scrambled after start.
  task automatic run_meas(input int gt, input int a, input int b, input int n, input bit do_start);
    int s, gl, e, f, l;
    gl = (gt < 1) ? 1 : gt;
    if (do_start) begin
      s = cyc;
      gate_time_i = gt;
      start_i = 1'b1;
      push(K_CLR, s + 1);
      @(negedge clk_i);
      start_i = 1'b0;
      gate_time_i = gt + 7;
      check_eq("busy_arm", busy_o, 1);
    end else begin
      s = cyc - 1;
    end
    e = s + a + 1;
    f = e + gl + b + 1;
    l = f + 1 + n;
    push(K_ON, e);
    push(K_OFF, f);
`ifdef GATE_SEQ_AUTO_REARM_EN
    push(K_CLR, l);
`endif
    push(K_LAT, l);
    push(K_DONE, l);
    wait_until(s + a);
    sig_edge_i = 1'b1;
    @(negedge clk_i);
    sig_edge_i = 1'b0;
    wait_until(f - 1);
    sig_edge_i = 1'b1;
    rd_busy_i = (n > 0);
    @(negedge clk_i);
    sig_edge_i = 1'b0;
    if (n > 0) begin
      wait_until(f + n);
      rd_busy_i = 1'b0;
    end
    wait_until(l);
`ifdef GATE_SEQ_AUTO_REARM_EN
    check_eq("busy_after_latch", busy_o, 1);
`else
    check_eq("busy_after_latch", busy_o, 0);
`endif
    check_eq("sb_empty_meas", exp_q.size(), 0);
  endtask

  task automatic stop_idle();
    stop_i = 1'b1;
    @(negedge clk_i);
    stop_i = 1'b0;
    @(negedge clk_i);
    check_eq("busy_after_stop", busy_o, 0);
    check_eq("sb_empty_stop", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    rst_n_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; sig_edge_i = 1'b0;
    rd_busy_i = 1'b0; gate_time_i = 32'd0;
    repeat (2) @(negedge clk_i);
    check_eq("rst_clr", cnt_clr_o, 0);
    check_eq("rst_en", cnt_en_o, 0);
    check_eq("rst_latch", latch_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_err", err_o, 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Nominal measurement, then with readout burst in LATCH, then zero gate time.
    run_meas(4, 3, 2, 0, 1'b1);
    stop_idle();
    run_meas(4, 3, 2, 5, 1'b1);
    stop_idle();
    run_meas(0, 1, 0, 0, 1'b1);
    stop_idle();

    // Watchdog in ARM: no signal edge at all.
    s = cyc;
    gate_time_i = 32'd3;
    start_i = 1'b1;
    push(K_CLR, s + 1);
    push(K_ERR, s + 4);
    @(negedge clk_i);
    start_i = 1'b0;
    wait_until(s + 4);
    check_eq("busy_wd_arm", busy_o, 0);
    check_eq("sb_empty_wd_arm", exp_q.size(), 0);
    repeat (2) @(negedge clk_i);

    // Watchdog in CLOSE: gate opens but never closes.
    s = cyc;
    gate_time_i = 32'd2;
    start_i = 1'b1;
    push(K_CLR, s + 1);
    push(K_ON, s + 2);
    push(K_OFF, s + 6);
    push(K_ERR, s + 6);
    @(negedge clk_i);
    start_i = 1'b0;
    sig_edge_i = 1'b1;
    @(negedge clk_i);
    sig_edge_i = 1'b0;
    wait_until(s + 6);
    check_eq("busy_wd_close", busy_o, 0);
    check_eq("sb_empty_wd_close", exp_q.size(), 0);

    // Stop in GATE; a start while busy is ignored.
    s = cyc;
    gate_time_i = 32'd6;
    start_i = 1'b1;
    push(K_CLR, s + 1);
    push(K_ON, s + 2);
    push(K_OFF, s + 4);
    @(negedge clk_i);
    start_i = 1'b0;
    sig_edge_i = 1'b1;
    @(negedge clk_i);
    sig_edge_i = 1'b0;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    stop_i = 1'b1;
    @(negedge clk_i);
    stop_i = 1'b0;
    check_eq("busy_stop_gate", busy_o, 0);
    @(negedge clk_i);
    check_eq("sb_empty_stop_gate", exp_q.size(), 0);

    // Simultaneous start and stop in IDLE is a stop.
    start_i = 1'b1;
    stop_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    stop_i = 1'b0;
    check_eq("busy_start_stop", busy_o, 0);
    @(negedge clk_i);
    check_eq("sb_empty_start_stop", exp_q.size(), 0);

`ifdef GATE_SEQ_AUTO_REARM_EN
    // Continuous mode: three back-to-back measurements from one start.
    run_meas(4, 2, 1, 0, 1'b1);
    run_meas(4, 2, 1, 0, 1'b0);
    run_meas(4, 2, 1, 0, 1'b0);
    stop_idle();
`endif

    // Asynchronous reset in the middle of the gate window.
    s = cyc;
    gate_time_i = 32'd5;
    start_i = 1'b1;
    push(K_CLR, s + 1);
    push(K_ON, s + 2);
    @(negedge clk_i);
    start_i = 1'b0;
    sig_edge_i = 1'b1;
    @(negedge clk_i);
    sig_edge_i = 1'b0;
    @(negedge clk_i);
    check_eq("en_before_rst", cnt_en_o, 1);
    rst_n_i = 1'b0;
    #1;
    check_eq("en_async_rst", cnt_en_o, 0);
    check_eq("busy_async_rst", busy_o, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check_eq("sb_empty_rst", exp_q.size(), 0);
    run_meas(2, 1, 1, 0, 1'b1);
    stop_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
